// File: rtl/terminal_src_fifo_if.sv
// Handshake bundle between a terminal source FIFO, its terminal agent and the mesh router port.
interface terminal_src_fifo_if #(
  parameter int unsigned pckg_sz    = 40,
  parameter int unsigned fifo_depth = 4
) ();
  localparam int unsigned CntW = $clog2(fifo_depth + 1);

  logic               push;
  logic [pckg_sz-1:0] data_in;
  logic               pop;
  logic               pndng;
  logic [pckg_sz-1:0] data_out;
  logic               full;
  logic [CntW-1:0]    count;
  logic [15:0]        drop_cnt;

  modport master (
    output push, data_in, pop,
    input  pndng, data_out, full, count, drop_cnt
  );

  modport slave (
    input  push, data_in, pop,
    output pndng, data_out, full, count, drop_cnt
  );
endinterface

// File: rtl/terminal_src_fifo.sv
// Per-terminal FWFT source FIFO feeding one mesh entry port; counts dropped pushes.
// Optional macro TERM_FIFO_DEST_CHECK_EN drops pushes whose row/col header is off-mesh.
module terminal_src_fifo #(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLUMS     = 4,
  parameter int unsigned pckg_sz    = 40,
  parameter int unsigned fifo_depth = 4
) (
  input logic                clk,
  input logic                reset,
  terminal_src_fifo_if.slave bus
);
  localparam int unsigned CntW = $clog2(fifo_depth + 1);
  localparam int unsigned PtrW = $clog2(fifo_depth);

  if (fifo_depth < 2 || fifo_depth > 64 || ROWS < 1 || ROWS > 14 ||
      COLUMS < 1 || COLUMS > 14) begin : g_bad_param
    $error("terminal_src_fifo: parameter out of range");
  end

  logic [pckg_sz-1:0] r_mem [fifo_depth];
  logic [PtrW-1:0]    r_rd_ptr;
  logic [PtrW-1:0]    r_wr_ptr;
  logic [CntW-1:0]    r_count;
  logic [15:0]        r_drop_cnt;

  logic w_full;
  logic w_pndng;
  logic w_pop_eff;
  logic w_dest_ok;
  logic w_push_acc;
  logic w_drop;

`ifdef TERM_FIFO_DEST_CHECK_EN
  logic [3:0] w_row;
  logic [3:0] w_col;

  always_comb begin
    w_row     = bus.data_in[pckg_sz-9 -: 4];
    w_col     = bus.data_in[pckg_sz-13 -: 4];
    w_dest_ok = (32'(w_row) <= ROWS + 32'd1) && (32'(w_col) <= COLUMS + 32'd1);
  end
`else
  assign w_dest_ok = 1'b1;
`endif

  assign w_full     = (r_count == CntW'(fifo_depth));
  assign w_pndng    = (r_count != '0);
  assign w_pop_eff  = bus.pop && w_pndng;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_push_acc = bus.push && w_dest_ok && (!w_full || w_pop_eff);
  assign w_drop     = bus.push && !w_push_acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(fifo_depth); i++) r_mem[i] <= '0;
    end else if (w_push_acc) begin
      r_mem[r_wr_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_pop_eff) begin
        r_rd_ptr <= (r_rd_ptr == PtrW'(fifo_depth - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      if (w_push_acc) begin
        r_wr_ptr <= (r_wr_ptr == PtrW'(fifo_depth - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_push_acc && !w_pop_eff) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push_acc && w_pop_eff) begin
        r_count <= r_count - 1'b1;
      end
      if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign bus.pndng    = w_pndng;
  assign bus.data_out = r_mem[r_rd_ptr];
  assign bus.full     = w_full;
  assign bus.count    = r_count;
  assign bus.drop_cnt = r_drop_cnt;
endmodule

// File: tb/tb_terminal_src_fifo.sv
// Self-checking bench for terminal_src_fifo: directed plan plus random traffic vs a queue model.
module tb_terminal_src_fifo;
  localparam int unsigned ROWS   = 4;
  localparam int unsigned COLUMS = 4;
  localparam int unsigned PW     = 40;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CW     = $clog2(DEPTH + 1);

  logic clk;
  logic reset;

  terminal_src_fifo_if #(.pckg_sz(PW), .fifo_depth(DEPTH)) bus ();

  terminal_src_fifo #(
    .ROWS      (ROWS),
    .COLUMS    (COLUMS),
    .pckg_sz   (PW),
    .fifo_depth(DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [PW-1:0] q[$];
  int m_drop = 0;

  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit dest_ok(input logic [PW-1:0] d);
`ifdef TERM_FIFO_DEST_CHECK_EN
    int row;
    int col;
    row = int'((d >> (PW - 12)) & 40'hF);
    col = int'((d >> (PW - 16)) & 40'hF);
    return (row <= int'(ROWS) + 1) && (col <= int'(COLUMS) + 1);
`else
    return (d === d);
`endif
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".count"}, PW'(bus.count), PW'(q.size()));
    chk({tag, ".pndng"}, PW'(bus.pndng), PW'(q.size() != 0));
    chk({tag, ".full"}, PW'(bus.full), PW'(q.size() == DEPTH));
    chk({tag, ".drop"}, PW'(bus.drop_cnt), PW'(m_drop));
    if (q.size() != 0) chk({tag, ".data"}, bus.data_out, q[0]);
  endtask

  // Drive one cycle starting at a falling edge; model updates at the rising edge.
  task automatic step(input logic p, input logic [PW-1:0] d, input logic pp, input string tag);
    bit pe;
    bit acc;
    bus.push    = p;
    bus.data_in = d;
    bus.pop     = pp;
    @(posedge clk);
    pe  = pp && (q.size() != 0);
    acc = p && dest_ok(d) && ((q.size() < DEPTH) || pe);
    if (pe) void'(q.pop_front());
    if (acc) q.push_back(d);
    if (p && !acc && m_drop < 65535) m_drop++;
    @(negedge clk);
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    check_state(tag);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".pndng"}, PW'(bus.pndng), '0);
    chk({tag, ".data"}, bus.data_out, '0);
    chk({tag, ".count"}, PW'(bus.count), '0);
    chk({tag, ".full"}, PW'(bus.full), '0);
    chk({tag, ".drop"}, PW'(bus.drop_cnt), '0);
  endtask

  initial begin
    logic [PW-1:0] d;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.data_in = '0;
    reset       = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("idle");

    step(1'b1, PW'('h11), 1'b0, "fill1");
    step(1'b1, PW'('h22), 1'b0, "fill2");
    step(1'b1, PW'('h33), 1'b0, "fill3");
    step(1'b1, PW'('h44), 1'b0, "fill4");
    chk("full_flag", PW'(bus.full), PW'(1));
    chk("full_head", bus.data_out, PW'('h11));
    step(1'b1, PW'('h55), 1'b0, "drop_full");
    chk("drop_one", PW'(bus.drop_cnt), PW'(1));
    step(1'b1, PW'('h55), 1'b1, "full_pushpop");
    chk("full_pp_head", bus.data_out, PW'('h22));
    chk("full_pp_cnt", PW'(bus.count), PW'(4));
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, "drain");
    chk("drained", PW'(bus.pndng), '0);

    step(1'b0, '0, 1'b1, "pop_empty");
    step(1'b1, PW'('hA5), 1'b1, "pushpop_empty");
    chk("pp_empty_data", bus.data_out, PW'('hA5));
    step(1'b0, '0, 1'b1, "drain2");

    step(1'b1, PW'(0), 1'b0, "wrap_seed");
    for (int i = 1; i <= 10; i++) begin
      chk("wrap_head", bus.data_out, PW'(i - 1));
      step(1'b1, PW'(i), 1'b1, "wrap");
    end
    step(1'b0, '0, 1'b1, "drain3");

    for (int i = 0; i < 400; i++) begin
      d = PW'({$urandom(), $urandom()});
`ifndef TERM_FIFO_DEST_CHECK_EN
      d = d;
`else
      if ($urandom_range(0, 3) != 0) d[PW-9 -: 8] = 8'($urandom_range(0, 5) * 16 + $urandom_range(0, 5));
`endif
      step(1'($urandom_range(0, 2) != 0), d, 1'($urandom_range(0, 1)), "rand");
    end
    while (q.size() != 0) step(1'b0, '0, 1'b1, "drain4");

    step(1'b1, PW'('h71), 1'b0, "pre_rst1");
    step(1'b1, PW'('h72), 1'b0, "pre_rst2");
    step(1'b1, PW'('h73), 1'b0, "pre_rst3");
    #2 reset = 1'b1;
    #1 check_reset_vals("async_rst");
    q.delete();
    m_drop = 0;
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, PW'('h99), 1'b0, "post_rst");

`ifdef TERM_FIFO_DEST_CHECK_EN
    while (q.size() != 0) step(1'b0, '0, 1'b1, "drain5");
    d = '0;
    d[PW-9 -: 8] = 8'h60;
    step(1'b1, d, 1'b0, "bad_row");
    chk("bad_row_drop", PW'(bus.drop_cnt), PW'(1));
    d[PW-9 -: 8] = 8'h55;
    step(1'b1, d, 1'b0, "edge_ok");
    chk("edge_ok_cnt", PW'(bus.count), PW'(1));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/terminal_src_fifo.md
# terminal_src_fifo

Per-terminal source FIFO feeding one mesh-network entry port. The terminal agent writes packets with `push`. The block presents the oldest packet to the mesh router as `pndng`/`data_out` with first-word fall-through, and the router consumes it with `pop`. There are `ROWS*2+COLUMS*2` instances, one per edge terminal. They drive the router's `pndng_i_in`/`data_out_i_in` inputs and receive its `popin` output.

## Interface
Parameters:
- `ROWS`, 4, mesh rows (informational; used only by the configuration feature).
- `COLUMS`, 4, mesh columns (same).
- `pckg_sz`, 40, packet width in bits.
- `fifo_depth`, 4, number of entries; legal range 2..64; need not be a power of two.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `push`  in  1  write request from terminal agent.
- `data_in`  in  `pckg_sz`  packet to write.
- `pop`  in  1  router consumes head packet (router's `popin`).
- `pndng`  out  1  FIFO non-empty; head packet valid on `data_out`.
- `data_out`  out  `pckg_sz`  head packet (FWFT).
- `full`  out  1  `count == fifo_depth`.
- `count`  out  `$clog2(fifo_depth+1)`  current occupancy.
- `drop_cnt`  out  16  packets discarded since reset.

## Operation
- Storage: `fifo_depth` x `pckg_sz` register array, with read pointer `rd_ptr`, write pointer `wr_ptr` and occupancy `count`.
- Pointer wrap: explicit compare. A pointer equal to `fifo_depth-1` goes to 0 on advance. No reliance on power-of-two rollover.
- Pop is effective when `pop && pndng`: `rd_ptr` advances and `count` decrements. Pop while empty is ignored, with no state change.
- Push is accepted when `push && (!full || pop_effective)`. `data_in` is written at `wr_ptr`, which advances, and `count` increments.
- Simultaneous accepted push and effective pop: both pointers advance and `count` is unchanged. This holds when full (the freed slot is reused in the same cycle).
- Push with `full` and no effective pop: the packet is dropped and `drop_cnt` increments, saturating at 0xFFFF.
- Push and pop when empty: the push is accepted and the pop is ignored, because `pndng` was 0. `count` becomes 1.
- `data_out` = `mem[rd_ptr]`, combinational from registers.
- `pndng` = `count != 0`.
- Reset, asynchronous and effective mid-operation:
  - `rd_ptr`, `wr_ptr` and `count` go to 0; all entries clear to 0.
  - `pndng`=0, `data_out`=0, `full`=0, `count`=0, `drop_cnt`=0.
  - A packet in flight is lost and is not counted as dropped.

## Timing
- Push accepted at edge N: `pndng`=1 and `data_out`=packet from after edge N. The router can pop it in the cycle following N (one-cycle write-to-read latency).
- Pop at edge N: the next packet, or `pndng`=0, is visible after edge N.
- Throughput: one push and one pop per cycle sustained.
- `full`, `count` and `drop_cnt` are registered-state derived and update after the edge that changes them.
- Reset deassertion: the first push is accepted at the first rising edge with `reset`=0.

## Configuration
- `TERM_FIFO_DEST_CHECK_EN`: compiles in a destination check at the write port.
  - Header fields: row = `data_in[pckg_sz-9:pckg_sz-12]`, col = `data_in[pckg_sz-13:pckg_sz-16]`.
  - A pushed packet is dropped when row > `ROWS+1` or col > `COLUMS+1`. These are the mesh-edge terminal coordinates, 0..ROWS+1 / 0..COLUMS+1.
  - A dropped packet is not written and increments `drop_cnt`, also saturating.
  - A single push that is both invalid and full counts once.
- Without the macro: no header inspection; every push that is not blocked by `full` is stored.

## Test plan
- Reset, then idle: `pndng`=0, `data_out`=0, `count`=0, `full`=0, `drop_cnt`=0.
- Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles (depth 4), no pop:
  - `full`=1 and `count`=4 after the 4th edge; `data_out`=0x11.
  - A 5th push of 0x55 gives `drop_cnt`=1 with contents unchanged.
- Full FIFO with push 0x55 and pop in the same cycle:
  - `count` stays 4, `data_out` becomes 0x22.
  - Draining yields 0x22, 0x33, 0x44, 0x55, then `pndng`=0.
- Wrap check: 10 cycles of simultaneous push/pop at occupancy 1, payloads 1..10 → output order 0..9 with no loss and `count`=1 throughout.
- Pop while empty, and push+pop while empty: `count` 0→0 and then 0→1, with `data_out` = pushed value.
- Assert `reset` asynchronously mid-cycle with 3 entries held: outputs go to 0 immediately without waiting for a clock edge, and `drop_cnt`=0.
- With `TERM_FIFO_DEST_CHECK_EN`, ROWS=COLUMS=4: push row=6 → dropped, `drop_cnt`=1; push row=5,col=5 → stored.
